// File: rtl/state_pkg.sv
// Shared player-state types and default motion constants for the movement,
// jump and draw logic.
package state_pkg;

    // Horizontal movement state used by the walking controller.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LEFT  = 2'd1,
        S_RIGHT = 2'd2
    } State;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } jump_state_t;

    localparam int YPOS_W = 12;
    localparam int POS_W  = 13;
    localparam int VEL_W  = 6;

    localparam int DEF_GROUND_Y = 600;
    localparam int DEF_CEIL_Y   = 0;
    localparam int DEF_JUMP_V0  = 12;
    localparam int DEF_GRAVITY  = 1;
    localparam int DEF_VMAX     = 16;

    function automatic logic [VEL_W-1:0] sat0_sub(input logic [VEL_W-1:0] a,
                                                   input logic [VEL_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/rise_edge.sv
// One-bit rising-edge detector: pulse while the input is high and its
// registered copy is still low.
module rise_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/player_jump_ctl.sv
// Vertical jump controller: frame-ticked GROUND/RISE/FALL motion with a
// single latched jump request, ceiling/floor clamps and a landing pulse.
module player_jump_ctl
    import state_pkg::*;
#(
    parameter int GROUND_Y = DEF_GROUND_Y,
    parameter int CEIL_Y   = DEF_CEIL_Y,
    parameter int JUMP_V0  = DEF_JUMP_V0,
    parameter int GRAVITY  = DEF_GRAVITY,
    parameter int VMAX     = DEF_VMAX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              v_tick,
    input  logic              m_jump,
    output logic [YPOS_W-1:0] ypos_player,
    output logic              airborne,
    output logic              landed,
    output jump_state_t       dbg_state,
    output logic [VEL_W-1:0]  dbg_vel
);

    localparam logic [POS_W-1:0]        GROUND_P = POS_W'(GROUND_Y);
    localparam logic signed [POS_W-1:0] CEIL_P   = POS_W'(CEIL_Y);
    localparam logic [VEL_W-1:0]        V0_V     = VEL_W'(JUMP_V0);
    localparam logic [VEL_W-1:0]        GRAV_S   = VEL_W'(GRAVITY);
    localparam logic [VEL_W:0]          GRAV_W   = (VEL_W + 1)'(GRAVITY);
    localparam logic [VEL_W:0]          VMAX_W   = (VEL_W + 1)'(VMAX);

    logic tick;
    logic press;

    rise_edge u_tick_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (v_tick),
        .rise_o (tick)
    );

    rise_edge u_jump_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (m_jump),
        .rise_o (press)
    );

    jump_state_t       state_q, state_d;
    logic [YPOS_W-1:0] ypos_q, ypos_d;
    logic [VEL_W-1:0]  vel_q, vel_d;
    logic              pending_q, pending_d;
    logic              airborne_q, airborne_d;
    logic              landed_q, landed_d;

    // 13-bit position math so a rise past 0 or a fall past 4095 is caught
    // by the clamps instead of wrapping.
    logic signed [POS_W-1:0] rise_pos;
    logic [POS_W-1:0]        fall_pos;
    logic [VEL_W:0]          vel_sum;
    logic [VEL_W-1:0]        vel_rise;
    logic [VEL_W-1:0]        vel_fall;

    assign rise_pos = $signed({1'b0, ypos_q}) - $signed({{(POS_W-VEL_W){1'b0}}, vel_q});
    assign vel_rise = sat0_sub(vel_q, GRAV_S);
    assign vel_sum  = {1'b0, vel_q} + GRAV_W;
    assign vel_fall = (vel_sum > VMAX_W) ? VMAX_W[VEL_W-1:0] : vel_sum[VEL_W-1:0];
    assign fall_pos = {1'b0, ypos_q} + {{(POS_W-VEL_W){1'b0}}, vel_fall};

    always_comb begin
        state_d   = state_q;
        ypos_d    = ypos_q;
        vel_d     = vel_q;
        pending_d = pending_q | press;
        landed_d  = 1'b0;

        case (state_q)
            GROUND: begin
                if (tick) begin
                    if (pending_q) begin
                        // A press landing in this same cycle stays latched
                        // for the next tick.
                        state_d   = RISE;
                        vel_d     = V0_V;
                        pending_d = press;
                    end else begin
                        ypos_d = GROUND_P[YPOS_W-1:0];
                        vel_d  = '0;
                    end
                end
            end
            RISE: begin
                if (tick) begin
                    pending_d = 1'b0;
                    if (rise_pos <= CEIL_P) begin
                        ypos_d  = CEIL_P[YPOS_W-1:0];
                        vel_d   = '0;
                        state_d = FALL;
                    end else begin
                        ypos_d = rise_pos[YPOS_W-1:0];
                        vel_d  = vel_rise;
                        if (vel_rise == '0) begin
                            state_d = FALL;
                        end
                    end
                end
            end
            FALL: begin
                if (tick) begin
                    pending_d = 1'b0;
                    if (fall_pos >= GROUND_P) begin
                        ypos_d   = GROUND_P[YPOS_W-1:0];
                        vel_d    = '0;
                        state_d  = GROUND;
                        landed_d = 1'b1;
                    end else begin
                        ypos_d = fall_pos[YPOS_W-1:0];
                        vel_d  = vel_fall;
                    end
                end
            end
            default: begin
                state_d   = GROUND;
                ypos_d    = GROUND_P[YPOS_W-1:0];
                vel_d     = '0;
                pending_d = 1'b0;
            end
        endcase

        airborne_d = (state_d == RISE) || (state_d == FALL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= GROUND;
            ypos_q     <= GROUND_P[YPOS_W-1:0];
            vel_q      <= '0;
            pending_q  <= 1'b0;
            airborne_q <= 1'b0;
            landed_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ypos_q     <= ypos_d;
            vel_q      <= vel_d;
            pending_q  <= pending_d;
            airborne_q <= airborne_d;
            landed_q   <= landed_d;
        end
    end

    assign ypos_player = ypos_q;
    assign airborne    = airborne_q;
    assign landed      = landed_q;
    assign dbg_state   = state_q;
    assign dbg_vel     = vel_q;

endmodule

// File: tb/tb_player_jump_ctl.sv
// Directed bench for player_jump_ctl: default jump arc, ceiling clamp,
// held/airborne presses, mid-air reset and a long v_tick level.
module tb_player_jump_ctl;
  import state_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic v_tick = 1'b0;
  logic m_jump = 1'b0;
  logic v_tick_b = 1'b0;
  logic m_jump_b = 1'b0;

  logic [11:0] ypos_a, ypos_b;
  logic air_a, air_b, land_a, land_b;
  jump_state_t st_a, st_b;
  logic [5:0] vel_a, vel_b;

  int checks = 0;
  int errors = 0;
  int land_cnt = 0;

  always #5 clk = ~clk;

  player_jump_ctl u_dut (
    .clk(clk), .rst_n(rst_n), .v_tick(v_tick), .m_jump(m_jump),
    .ypos_player(ypos_a), .airborne(air_a), .landed(land_a),
    .dbg_state(st_a), .dbg_vel(vel_a)
  );

  player_jump_ctl #(.CEIL_Y(550)) u_dut_ceil (
    .clk(clk), .rst_n(rst_n), .v_tick(v_tick_b), .m_jump(m_jump_b),
    .ypos_player(ypos_b), .airborne(air_b), .landed(land_b),
    .dbg_state(st_b), .dbg_vel(vel_b)
  );

  // Counts clocks during which landed is high (sampled mid-cycle).
  always @(negedge clk) if (land_a) land_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit on_b, input bit with_press);
    @(negedge clk);
    if (on_b) begin
      v_tick_b = 1'b1;
      if (with_press) m_jump_b = 1'b1;
    end else begin
      v_tick = 1'b1;
      if (with_press) m_jump = 1'b1;
    end
    @(negedge clk);
    v_tick = 1'b0;
    v_tick_b = 1'b0;
    if (with_press) begin
      m_jump = 1'b0;
      m_jump_b = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic press(input bit on_b);
    @(negedge clk);
    if (on_b) m_jump_b = 1'b1; else m_jump = 1'b1;
    @(negedge clk);
    m_jump = 1'b0;
    m_jump_b = 1'b0;
  endtask

  // From RISE with vel=12 at ypos 600: 12 rise ticks then 12 fall ticks.
  task automatic fly(input string tag, input int press_at);
    int exp_y = 600;
    int exp_v = 12;
    int l0 = land_cnt;
    for (int i = 0; i < 24; i++) begin
      tick(1'b0, i == press_at);
      if (i < 12) begin
        exp_y -= exp_v;
        exp_v--;
      end else begin
        exp_v++;
        exp_y += exp_v;
      end
      chk({tag, "_y"}, 32'(ypos_a), 32'(exp_y));
      if (i == 11) begin
        chk({tag, "_top_y"}, 32'(ypos_a), 32'd522);
        chk({tag, "_top_state"}, 32'(st_a), 32'(FALL));
      end
      if (i < 23) chk({tag, "_air"}, 32'(air_a), 32'd1);
    end
    chk({tag, "_land_state"}, 32'(st_a), 32'(GROUND));
    chk({tag, "_land_air"}, 32'(air_a), 32'd0);
    chk({tag, "_land_pulses"}, 32'(land_cnt - l0), 32'd1);
  endtask

  initial begin
    int l0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_y", 32'(ypos_a), 32'd600);
    chk("rst_state", 32'(st_a), 32'(GROUND));
    chk("rst_vel", 32'(vel_a), 32'd0);
    chk("rst_air", 32'(air_a), 32'd0);
    chk("rst_land", 32'(land_a), 32'd0);
    rst_n = 1'b1;

    // First tick after release without a press must not launch
    tick(1'b0, 1'b0);
    chk("notlaunch_state", 32'(st_a), 32'(GROUND));
    chk("notlaunch_y", 32'(ypos_a), 32'd600);

    // One press pulse, then a full 25-tick jump
    press(1'b0);
    tick(1'b0, 1'b0);
    chk("launch_state", 32'(st_a), 32'(RISE));
    chk("launch_y", 32'(ypos_a), 32'd600);
    chk("launch_vel", 32'(vel_a), 32'd12);
    chk("launch_air", 32'(air_a), 32'd1);
    fly("jump1", -1);

    // Ceiling clamp at 550
    press(1'b1);
    tick(1'b1, 1'b0);
    chk("ceil_launch", 32'(st_b), 32'(RISE));
    tick(1'b1, 1'b0); chk("ceil_y1", 32'(ypos_b), 32'd588);
    tick(1'b1, 1'b0); chk("ceil_y2", 32'(ypos_b), 32'd577);
    tick(1'b1, 1'b0); chk("ceil_y3", 32'(ypos_b), 32'd567);
    tick(1'b1, 1'b0); chk("ceil_y4", 32'(ypos_b), 32'd558);
    tick(1'b1, 1'b0);
    chk("ceil_y5", 32'(ypos_b), 32'd550);
    chk("ceil_vel", 32'(vel_b), 32'd0);
    chk("ceil_state", 32'(st_b), 32'(FALL));

    // m_jump held high across a whole jump and landing
    @(negedge clk);
    m_jump = 1'b1;
    tick(1'b0, 1'b0);
    chk("held_launch", 32'(st_a), 32'(RISE));
    fly("held", -1);
    repeat (3) tick(1'b0, 1'b0);
    chk("held_stay_state", 32'(st_a), 32'(GROUND));
    chk("held_stay_y", 32'(ypos_a), 32'd600);
    @(negedge clk);
    m_jump = 1'b0;
    tick(1'b0, 1'b0);
    chk("released_state", 32'(st_a), 32'(GROUND));
    press(1'b0);
    tick(1'b0, 1'b0);
    chk("repress_launch", 32'(st_a), 32'(RISE));

    // Airborne press at RISE tick 3 is discarded
    fly("nodouble", 2);
    repeat (2) tick(1'b0, 1'b0);
    chk("nodouble_state", 32'(st_a), 32'(GROUND));
    chk("nodouble_y", 32'(ypos_a), 32'd600);

    // Reset asserted at FALL tick 5
    press(1'b0);
    tick(1'b0, 1'b0);
    repeat (17) tick(1'b0, 1'b0);
    chk("pre_rst_y", 32'(ypos_a), 32'd537);
    chk("pre_rst_state", 32'(st_a), 32'(FALL));
    l0 = land_cnt;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_y", 32'(ypos_a), 32'd600);
    chk("async_rst_air", 32'(air_a), 32'd0);
    chk("async_rst_land", 32'(land_a), 32'd0);
    chk("async_rst_state", 32'(st_a), 32'(GROUND));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_no_land", 32'(land_cnt - l0), 32'd0);

    // Press edge in the same cycle as a GROUND tick waits for the next tick
    tick(1'b0, 1'b1);
    chk("same_cycle_state", 32'(st_a), 32'(GROUND));
    tick(1'b0, 1'b0);
    chk("next_tick_state", 32'(st_a), 32'(RISE));
    chk("next_tick_vel", 32'(vel_a), 32'd12);

    // v_tick held high for 100 clocks gives exactly one update
    @(negedge clk);
    v_tick = 1'b1;
    repeat (100) @(negedge clk);
    v_tick = 1'b0;
    @(negedge clk);
    chk("long_tick_y", 32'(ypos_a), 32'd588);
    chk("long_tick_vel", 32'(vel_a), 32'd11);
    chk("long_tick_state", 32'(st_a), 32'(RISE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
